uart_upstream_scheduler: RTL

//  Round-robin scheduler that shares the single upstream UART TX (uart_tx_to_fpga side of Uart1To20Top) among NCH channel RX FIFOs.
//  - Drains a burst from the granted channel FIFO into a local payload buffer.
//  - Emits the burst as one frame: 24 43 54 46 | LEN | CH | data[LEN] | CRC0 | CRC1 | FE.
//  - Sits between the 20 per-channel UART receivers' FIFOs and the shared upstream UART transmitter.

---
 rtl/uart_upstream_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_upstream_scheduler.sv
// uart_upstream_scheduler
//   Round-robin scheduler sharing one upstream UART TX among NCH channel RX FIFOs.
//   The granted channel's show-ahead FIFO is drained into a local payload buffer.
//   Gathering stops when the buffer is full, or after GAP_CYC idle cycles once at
//   least one byte is held. The payload then goes out as one frame:
//     24 43 54 46 | LEN | CH | data[LEN] | CRC0 | CRC1 | FE
//   CRC is the 16-bit sum of LEN, CH and the data bytes, sent low byte first.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   en_mask[NCH]          channel may be granted
//   ch_empty[NCH]         per-channel FIFO empty
//   ch_rd_data[NCH*8]     FIFO head bytes, channel i at [8i+7:8i]
//   ch_rd_en[NCH]         one-hot pop strobe, GATHER only
//   tx_data/valid/ready   byte stream to the UART TX, transfer = valid & ready
//   busy, grant_id        grant in progress and granted channel index
//   frame_done            1-cycle pulse after the END byte is accepted
module uart_upstream_scheduler #(
   parameter int unsigned NCH         = 20,
   parameter int unsigned MAX_PAYLOAD = 16,
   parameter int unsigned GAP_CYC     = 1024,
   parameter logic [7:0]  CH_BASE     = 8'h11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   en_mask,
   input  logic [NCH-1:0]   ch_empty,
   input  logic [NCH*8-1:0] ch_rd_data,
   output logic [NCH-1:0]   ch_rd_en,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic [4:0]       grant_id,
   output logic             frame_done
);

   localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);
   localparam int unsigned GW = $clog2(GAP_CYC + 1);
   localparam int unsigned IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

   typedef enum logic [3:0] {
      StIdle, StGather, StHdr0, StHdr1, StHdr2, StHdr3,
      StLen, StCh, StData, StCrc0, StCrc1, StEnd
   } state_e;

   state_e          state_q, state_d;
   logic [4:0]      ptr_q, ptr_d;
   logic [4:0]      grant_id_q, grant_id_d;
   logic            busy_q, busy_d;
   logic            frame_done_q, frame_done_d;
   logic            tx_valid_q, tx_valid_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [15:0]     sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      pay_q [MAX_PAYLOAD];
   logic [7:0]      pay_d [MAX_PAYLOAD];

   logic [NCH-1:0]  req;
   logic            found;
   logic [4:0]      pick;
   int unsigned     cand;
   logic [7:0]      head;
   logic [7:0]      ch_byte;
   logic [15:0]     crc;
   logic            tx_fire;

   always_comb begin
      req      = ~ch_empty & en_mask;
      found    = 1'b0;
      pick     = '0;
      cand     = 0;
      // First requester at or after the pointer, wrapping modulo NCH.
      for (int unsigned off = 0; off < NCH; off++) begin
         cand = int'(ptr_q) + off;
         if (cand >= NCH) cand = cand - NCH;
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = 5'(cand);
         end
      end

      head    = ch_rd_data[int'(grant_id_q)*8 +: 8];
      ch_byte = CH_BASE + 8'(grant_id_q);
      crc     = sum_q + 16'(cnt_q) + 16'(ch_byte);
      tx_fire = tx_valid_q & tx_ready;

      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_id_d   = grant_id_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      sum_d        = sum_q;
      idx_d        = idx_q;
      pay_d        = pay_q;
      ch_rd_en     = '0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_id_d = pick;
               busy_d     = 1'b1;
               cnt_d      = '0;
               gap_d      = '0;
               sum_d      = '0;
               state_d    = StGather;
            end
         end
         StGather: begin
            if (cnt_q == CW'(MAX_PAYLOAD)) begin
               state_d = StHdr0;
            end else if (gap_q == GW'(GAP_CYC) && cnt_q != '0) begin
               state_d = StHdr0;
            end else if (!ch_empty[grant_id_q]) begin
               ch_rd_en[grant_id_q]  = 1'b1;
               pay_d[cnt_q[IW-1:0]] = head;
               cnt_d                = cnt_q + CW'(1);
               sum_d                = sum_q + 16'(head);
               gap_d                = '0;
            end else if (gap_q != GW'(GAP_CYC)) begin
               // Saturate so a stalled empty FIFO never wraps the counter.
               gap_d = gap_q + GW'(1);
            end
         end
         StHdr0: if (tx_fire) state_d = StHdr1;
         StHdr1: if (tx_fire) state_d = StHdr2;
         StHdr2: if (tx_fire) state_d = StHdr3;
         StHdr3: if (tx_fire) state_d = StLen;
         StLen:  if (tx_fire) state_d = StCh;
         StCh: begin
            if (tx_fire) begin
               idx_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (tx_fire) begin
               if (CW'(idx_q) == cnt_q - CW'(1)) state_d = StCrc0;
               else idx_d = idx_q + IW'(1);
            end
         end
         StCrc0: if (tx_fire) state_d = StCrc1;
         StCrc1: if (tx_fire) state_d = StEnd;
         StEnd: begin
            if (tx_fire) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               ptr_d        = (grant_id_q == 5'(NCH - 1)) ? 5'd0 : grant_id_q + 5'd1;
               cnt_d        = '0;
               sum_d        = '0;
               gap_d        = '0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered from the next state so tx_data holds while stalled.
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h00;
      unique case (state_d)
         StHdr0:  tx_data_d = 8'h24;
         StHdr1:  tx_data_d = 8'h43;
         StHdr2:  tx_data_d = 8'h54;
         StHdr3:  tx_data_d = 8'h46;
         StLen:   tx_data_d = 8'(cnt_d);
         StCh:    tx_data_d = ch_byte;
         StData:  tx_data_d = pay_q[idx_d];
         StCrc0:  tx_data_d = crc[7:0];
         StCrc1:  tx_data_d = crc[15:8];
         StEnd:   tx_data_d = 8'hFE;
         default: tx_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         grant_id_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         sum_q        <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         sum_q        <= sum_d;
         idx_q        <= idx_d;
      end
   end

   // Payload storage carries no reset; it is always written before being read.
   always_ff @(posedge clk) begin
      pay_q <= pay_d;
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;
   assign frame_done = frame_done_q;

endmodule
